// File: rtl/td_pkg.sv
// Shared types and default PAL/NTSC sync windows for the TD sync monitor.
package td_pkg;
   typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED, LOSING} tdState_t;

   localparam int CNT_W            = 8;
   localparam int DEF_PAL_VLO_MIN  = 24;
   localparam int DEF_PAL_VLO_MAX  = 25;
   localparam int DEF_PAL_TOT_MIN  = 310;
   localparam int DEF_PAL_TOT_MAX  = 315;
   localparam int DEF_NTSC_VLO_MIN = 9;
   localparam int DEF_NTSC_VLO_MAX = 10;
   localparam int DEF_NTSC_TOT_MIN = 260;
   localparam int DEF_NTSC_TOT_MAX = 265;

   // Hysteresis state carried from field to field.
   typedef struct packed {
      tdState_t         state;
      logic [CNT_W-1:0] goodCnt;
      logic [CNT_W-1:0] badCnt;
      logic             stdPal;
      logic             pal;
      logic             timeout;
   } tdFsm_t;

   function automatic logic inWin(input int v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction
endpackage

// File: rtl/td_edge_sync.sv
// Two-flop synchroniser with a delay flop; emits level and one-cycle edge pulses.
module td_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [2:0] sh;   // [0] metastable, [1] synced, [2] delayed

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sh <= '0;
      else     sh <= {sh[1:0], din};
   end

   assign level = sh[1];
   assign rise  = sh[1] & ~sh[2];
   assign fall  = ~sh[1] & sh[2];
endmodule

// File: rtl/td_sync_monitor.sv
// Sync monitor: measures VS-low and total lines per field, validates against
// PAL/NTSC windows and drives a lock/unlock hysteresis FSM with VS timeout.
module td_sync_monitor import td_pkg::*; #(
   parameter int LINE_W        = 10,
   parameter int PAL_VLO_MIN   = DEF_PAL_VLO_MIN,
   parameter int PAL_VLO_MAX   = DEF_PAL_VLO_MAX,
   parameter int PAL_TOT_MIN   = DEF_PAL_TOT_MIN,
   parameter int PAL_TOT_MAX   = DEF_PAL_TOT_MAX,
   parameter int NTSC_VLO_MIN  = DEF_NTSC_VLO_MIN,
   parameter int NTSC_VLO_MAX  = DEF_NTSC_VLO_MAX,
   parameter int NTSC_TOT_MIN  = DEF_NTSC_TOT_MIN,
   parameter int NTSC_TOT_MAX  = DEF_NTSC_TOT_MAX,
   parameter int LOCK_FIELDS   = 4,
   parameter int UNLOCK_FIELDS = 2,
   parameter int TO_W          = 21,
   parameter int VS_TIMEOUT    = 1080000
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iTD_HS,
   input  logic              iTD_VS,
   input  logic              iMODE_AUTO,
   input  logic              iMODE_SEL,
   output logic              oTD_Stable,
   output logic              oTD_PAL,
   output logic [LINE_W-1:0] oLINE_CNT,
   output logic [LINE_W-1:0] oVLO_CNT,
   output logic              oFIELD_STB,
   output logic              oTIMEOUT
);
   localparam logic [LINE_W-1:0] LINE_MAX = '1;
   localparam logic [TO_W-1:0]   TO_MAX   = '1;
   localparam logic [TO_W-1:0]   TO_HIT   = TO_W'(VS_TIMEOUT - 1);

   logic hsLvl, hsRise, hsFall, vsLvl, vsRise, vsFall;
   logic unusedOk;
   logic [LINE_W-1:0] totCnt, vloCnt, lineCnt, vloOut;
   logic [TO_W-1:0]   toCnt;
   logic              fieldStb;
   logic              palOk, ntscOk, fieldOk, cand, sameOk;
   tdFsm_t            cur, nxt;

   td_edge_sync uHs (.clk(iCLK), .rst(iRST), .din(iTD_HS), .level(hsLvl), .rise(hsRise), .fall(hsFall));
   td_edge_sync uVs (.clk(iCLK), .rst(iRST), .din(iTD_VS), .level(vsLvl), .rise(vsRise), .fall(vsFall));
   assign unusedOk = &{1'b0, hsLvl, hsFall, vsFall};

   // A line whose HS coincides with the VS rise belongs to the new field.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         totCnt   <= '0;
         vloCnt   <= '0;
         lineCnt  <= '0;
         vloOut   <= '0;
         fieldStb <= 1'b0;
         toCnt    <= '0;
      end else begin
         if (vsRise) begin
            lineCnt <= totCnt;
            vloOut  <= vloCnt;
            vloCnt  <= '0;
            totCnt  <= {{(LINE_W-1){1'b0}}, hsRise};
         end else if (hsRise) begin
            if (totCnt != LINE_MAX)          totCnt <= totCnt + 1'b1;
            if (!vsLvl && vloCnt != LINE_MAX) vloCnt <= vloCnt + 1'b1;
         end
         fieldStb <= vsRise;
         toCnt    <= vsRise ? '0 : ((toCnt == TO_MAX) ? toCnt : toCnt + 1'b1);
      end
   end

   assign palOk   = inWin(int'(vloCnt), PAL_VLO_MIN, PAL_VLO_MAX) &&
                    inWin(int'(totCnt), PAL_TOT_MIN, PAL_TOT_MAX);
   assign ntscOk  = inWin(int'(vloCnt), NTSC_VLO_MIN, NTSC_VLO_MAX) &&
                    inWin(int'(totCnt), NTSC_TOT_MIN, NTSC_TOT_MAX);
   assign fieldOk = iMODE_AUTO ? (palOk | ntscOk) : (iMODE_SEL ? palOk : ntscOk);
   assign cand    = iMODE_AUTO ? palOk : iMODE_SEL;
   assign sameOk  = fieldOk && (cand == cur.stdPal);

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) cur <= '{state: UNLOCKED, goodCnt: '0, badCnt: '0, stdPal: 1'b1, pal: 1'b1, timeout: 1'b0};
      else      cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      if (vsRise) begin
         nxt.timeout = 1'b0;
         case (cur.state)
            UNLOCKED: if (fieldOk) begin
               nxt.stdPal  = cand;
               nxt.goodCnt = CNT_W'(1);
               if (LOCK_FIELDS <= 1) begin
                  nxt.state = LOCKED;
                  nxt.pal   = cand;
               end else nxt.state = LOCKING;
            end
            LOCKING: if (sameOk) begin
               nxt.goodCnt = cur.goodCnt + 1'b1;
               if (int'(cur.goodCnt) + 1 >= LOCK_FIELDS) begin
                  nxt.state = LOCKED;
                  nxt.pal   = cur.stdPal;
               end
            end else nxt.state = UNLOCKED;
            LOCKED: if (!sameOk) begin
               nxt.badCnt = CNT_W'(1);
               nxt.state  = (UNLOCK_FIELDS <= 1) ? UNLOCKED : LOSING;
            end
            LOSING: if (sameOk) begin
               nxt.state  = LOCKED;
               nxt.badCnt = '0;
               nxt.pal    = cur.stdPal;
            end else begin
               nxt.badCnt = cur.badCnt + 1'b1;
               if (int'(cur.badCnt) + 1 >= UNLOCK_FIELDS) nxt.state = UNLOCKED;
            end
            default: nxt.state = UNLOCKED;
         endcase
      end else if (toCnt == TO_HIT) begin
         nxt.state   = UNLOCKED;
         nxt.timeout = 1'b1;
      end
   end

   assign oTD_Stable = (cur.state == LOCKED) || (cur.state == LOSING);
   assign oTD_PAL    = cur.pal;
   assign oTIMEOUT   = cur.timeout;
   assign oFIELD_STB = fieldStb;
   assign oLINE_CNT  = lineCnt;
   assign oVLO_CNT   = vloOut;
endmodule
